tile_palette_pipe: RTL
======================

Name: tile_palette_pipe

Overview:
- Pipelined, programmable-palette tile colourer for the minesweeper VGA renderer.
- Sits between the board-state reader and the pixel output mux. Each valid input is a tile state plus its adjacent-mine count; the block returns a COLOR_W-bit RGB value.
- Features: writable palette, blinking exploded-mine colour, and cursor highlight.

Parameters:
- COLOR_W, 24, output colour width; must be a multiple of 3; channel width CW = COLOR_W/3, ordered R,G,B from MSB.
- COUNT_W, 4, width of the adjacent-mine count.
- BLINK_DIV, 25000000, clock cycles per blink half-period; must be >= 1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input tile descriptor valid.
- in_state  in  3  tile state: 0 hidden, 1 revealed, 2 flagged, 3 mine, 4 exploded; 5-7 invalid.
- in_count  in  COUNT_W  adjacent-mine count; used only when in_state=1.
- in_cursor  in  1  tile is under the player cursor.
- pal_we  in  1  palette write strobe.
- pal_addr  in  4  palette entry index.
- pal_wdata  in  COLOR_W  palette write data.
- out_valid  out  1  out_color valid.
- out_color  out  COLOR_W  resolved tile colour.

Behaviour:
- Palette: 16 x COLOR_W registers. Reset values are given for COLOR_W=24; for other widths, scale each channel by taking its top CW bits.
  - 0 FFFFFF, 1 FAFFA6, 2 FF6F00, 3 2FFF00, 4 00FFE1, 5 00B3FF, 6 9382C2, 7 FF00EE, 8 34003B.
  - 9 A6A6A6 (hidden), 10 FF0000 (flag), 11 000000 (mine / exploded phase 1), 12 FF3000 (exploded phase 0), 13 000000 (unused), 14 808080 (revealed count > 8), 15 FF00FF (invalid state).
- Palette write: when pal_we=1, entry pal_addr takes pal_wdata at the clock edge. Writes are independent of in_valid.
- Stage 1 (registered), computes the index:
  - state 0 -> 9; state 1 -> count if count <= 8, else 14; state 2 -> 10; state 3 -> 11; state 4 -> 12 or 11 per blink phase; states 5-7 -> 15.
  - in_valid and in_cursor are carried along into stage 1.
- Stage 2 (registered): reads the palette at the stage-1 index and applies the cursor highlight, then registers out_color and out_valid.
  - Highlight, per channel: c' = c + ((2^CW-1 - c) >> 1). No overflow is possible, and all-ones stays all-ones.
  - The highlight is applied only when in_cursor was 1 and the state was not 5-7.
- Latency: exactly 2 cycles from in_valid to out_valid. Fully pipelined: one tile per cycle, no backpressure, no stalls.
- When in_valid=0, the bubble propagates: out_valid=0 and out_color holds its previous value.
- Write/read collision: the stage-2 read samples the palette before the same-edge write, so it returns old data. The new value is visible to reads in the following cycle.
- Blink:
  - A counter counts 0..BLINK_DIV-1 and free-runs regardless of in_valid.
  - On wrap to 0, blink_phase toggles.
  - Stage 1 samples the phase that is current in the cycle in_valid is presented.
  - With BLINK_DIV=1, the phase toggles every cycle.
- Reset (asserted at any time, including mid-stream):
  - out_valid=0, out_color=0, both pipeline stages cleared to invalid.
  - Palette returns to reset values; blink counter=0, blink_phase=0.
  - In-flight tiles are discarded; the first valid output after deassertion appears 2 cycles after the first post-reset in_valid.
- Width rules:
  - in_count is compared unsigned against 8.
  - If COUNT_W < 4, all count values <= 8 that are representable map directly.

Test Plan:
- After reset, stream states 1 with counts 0..8, then count 9 and count 15 (COLOR_W=24) -> out_valid rises on cycle 3. Colours in order: FFFFFF, FAFFA6, FF6F00, 2FFF00, 00FFE1, 00B3FF, 9382C2, FF00EE, 34003B, then 808080, 808080. No gaps in out_valid.
- States 0, 2, 3, 6 with in_cursor=0 -> A6A6A6, FF0000, 000000, FF00FF. The same states with in_cursor=1 -> D2D2D2, FF7F7F, 7F7F7F, FF00FF.
- BLINK_DIV=4, hold state 4 with in_valid=1 for 16 cycles -> out_color alternates FF3000 x4, 000000 x4, repeating, with a 2-cycle output latency.
- Write pal_addr=3, pal_wdata=123456 on the same edge that a count-3 tile is in stage 2 -> that output = 2FFF00. A count-3 tile presented the next cycle outputs 123456.
- Pulse rst_n low for 1 cycle while 2 tiles are in flight, also after a palette write to entry 3 -> out_valid=0 and out_color=0 immediately (asynchronous). In-flight tiles never appear. A count-3 tile after reset yields 2FFF00.
- Random mix of in_valid bubbles and states against a reference model -> out_valid pattern equals in_valid delayed 2 cycles, and colours match exactly.

Source files
------------

// File: rtl/tile_palette_pipe.sv
// Two-stage tile colourer: state/count -> palette index, then palette lookup
// with optional cursor highlight. Palette is writable; exploded mines blink.
module tile_palette_pipe #(
  parameter int unsigned COLOR_W   = 24,
  parameter int unsigned COUNT_W   = 4,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [2:0]         in_state,
  input  logic [COUNT_W-1:0] in_count,
  input  logic               in_cursor,
  input  logic               pal_we,
  input  logic [3:0]         pal_addr,
  input  logic [COLOR_W-1:0] pal_wdata,
  output logic               out_valid,
  output logic [COLOR_W-1:0] out_color
);

  localparam int unsigned CW = COLOR_W / 3;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [3:0] IDX_HIDDEN  = 4'd9;
  localparam logic [3:0] IDX_FLAG    = 4'd10;
  localparam logic [3:0] IDX_MINE    = 4'd11;
  localparam logic [3:0] IDX_EXPLODE = 4'd12;
  localparam logic [3:0] IDX_BIGCNT  = 4'd14;
  localparam logic [3:0] IDX_INVALID = 4'd15;

  // Reset palette defined at 8 bits per channel, rescaled to CW bits per channel.
  function automatic logic [COLOR_W-1:0] rst_entry(input int unsigned idx);
    logic [23:0]        v;
    logic [31:0]        t;
    logic [COLOR_W-1:0] r;
    case (idx)
      0:       v = 24'hFFFFFF;
      1:       v = 24'hFAFFA6;
      2:       v = 24'hFF6F00;
      3:       v = 24'h2FFF00;
      4:       v = 24'h00FFE1;
      5:       v = 24'h00B3FF;
      6:       v = 24'h9382C2;
      7:       v = 24'hFF00EE;
      8:       v = 24'h34003B;
      9:       v = 24'hA6A6A6;
      10:      v = 24'hFF0000;
      12:      v = 24'hFF3000;
      14:      v = 24'h808080;
      15:      v = 24'hFF00FF;
      default: v = 24'h000000;
    endcase
    r = '0;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      t = 32'(v[ch*8 +: 8]);
      if (CW <= 8) t = t >> (8 - CW);
      else         t = t << (CW - 8);
      r[ch*CW +: CW] = CW'(t);
    end
    return r;
  endfunction

  // Move each channel halfway towards full scale.
  function automatic logic [COLOR_W-1:0] highlight(input logic [COLOR_W-1:0] c);
    logic [CW-1:0]      x;
    logic [COLOR_W-1:0] r;
    r = '0;
    for (int unsigned ch = 0; ch < 3; ch++) begin
      x = c[ch*CW +: CW];
      r[ch*CW +: CW] = x + (~x >> 1);
    end
    return r;
  endfunction

  logic [COLOR_W-1:0] pal_q [16];
  logic [BW-1:0]      blink_cnt_q;
  logic               blink_phase_q;

  logic               s1_valid_q;
  logic [3:0]         s1_idx_q, s1_idx_d;
  logic               s1_hl_q, s1_hl_d;

  logic               out_valid_q;
  logic [COLOR_W-1:0] out_color_q, out_color_d;
  logic [COLOR_W-1:0] pal_rd_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 16; i++) pal_q[i] <= rst_entry(i);
    end else if (pal_we) begin
      pal_q[pal_addr] <= pal_wdata;
    end
  end

  // Free-running blink divider; phase flips each time the counter wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= ~blink_phase_q;
    end else begin
      blink_cnt_q   <= blink_cnt_q + BW'(1);
    end
  end

  always_comb begin
    s1_idx_d = IDX_INVALID;
    s1_hl_d  = in_cursor && (in_state < 3'd5);
    case (in_state)
      3'd0: s1_idx_d = IDX_HIDDEN;
      3'd1: s1_idx_d = (32'(in_count) <= 32'd8) ? 4'(in_count) : IDX_BIGCNT;
      3'd2: s1_idx_d = IDX_FLAG;
      3'd3: s1_idx_d = IDX_MINE;
      3'd4: s1_idx_d = blink_phase_q ? IDX_MINE : IDX_EXPLODE;
      default: s1_idx_d = IDX_INVALID;
    endcase
  end

  always_comb begin
    pal_rd_c    = pal_q[s1_idx_q];
    out_color_d = out_color_q;
    if (s1_valid_q) out_color_d = s1_hl_q ? highlight(pal_rd_c) : pal_rd_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_idx_q    <= '0;
      s1_hl_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_color_q <= '0;
    end else begin
      s1_valid_q  <= in_valid;
      s1_idx_q    <= s1_idx_d;
      s1_hl_q     <= s1_hl_d;
      out_valid_q <= s1_valid_q;
      out_color_q <= out_color_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_color = out_color_q;

endmodule
